peripheral_timer_bank: RTL
==========================

Name: peripheral_timer_bank

Overview:
Parametrised successor to the single-timer peripheral block; it sits on the CPU data-memory bus in the 0x4000_0000 I/O region.
- Provides NUM_TIMERS independent timer channels, each with a prescaler, auto-reload or one-shot mode, and a sticky write-1-to-clear interrupt status.
- Keeps the LED, switch and 7-segment (digi) registers at parametrised widths.
- Drives one OR-ed interrupt line to the CPU plus a per-channel vector.

Parameters:
NUM_TIMERS, 2, number of timer channels (1..8)
TIMER_W, 32, width of TH/TL counters
PRESC_W, 16, width of prescaler register
LED_W, 8, LED register width
SW_W, 8, switch input width
DIGI_W, 12, 7-segment drive width
BASE_ADDR, 32'h40000000, base of register window

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous active-low reset (negedge reset clears all state)
rd  input  1  read strobe
wr  input  1  write strobe, sampled at posedge clk
addr  input  32  byte address, full 32-bit decode
wdata  input  32  write data
rdata  output  32  read data, combinational
led  output  LED_W  LED register
switch  input  SW_W  switch inputs, read-only
digi  output  DIGI_W  7-segment register
irq_vec  output  NUM_TIMERS  per-channel status & ien
irqout  output  1  OR of irq_vec

Behaviour:
- Map: channel i at BASE+0x10*i; +0x0 TH (reload value), +0x4 TL (counter), +0x8 TCON, +0xC PRESC.
- Global registers: BASE+0x80 LED, +0x84 SWITCH (RO), +0x88 DIGI, +0x8C IRQSTAT (bit i = status of channel i).
- TCON bits: [0] en, [1] ien, [2] oneshot, [3] status. Bits [31:4] read 0.
- Write to TCON loads [2:0]; wdata[3]=1 clears status (W1C). Writing IRQSTAT with bit i=1 also clears channel i status.
- rdata: zero-extended register value when rd=1 and the address matches exactly; 0 when rd=0, unmapped, or unaligned. Reads have no side effects.
- Reset: TH, TL, TCON, PRESC, prescaler count, led, digi all 0. Outputs irqout=0, irq_vec=0.
- Prescaler:
  - Internal pcnt (PRESC_W) counts while en=1.
  - A tick occurs when pcnt==PRESC, then pcnt<=0; PRESC=0 gives a tick every cycle.
  - pcnt is held at 0 while en=0 and on any write to PRESC or TCON.
- On tick: if TL != all-ones, TL<=TL+1. If TL==all-ones (overflow):
  - TL<=TH.
  - status<=1, independent of ien.
  - If oneshot=1, en<=0.
- Interrupt output: irq_vec[i]=status&ien; irqout=|irq_vec. Both are registered-state derived, so they assert the cycle after the overflow edge.
- Simultaneous events, same cycle:
  - CPU write to TL or TH wins over tick/overflow update of that register.
  - CPU write to TCON wins for en/ien/oneshot.
  - Overflow set wins over W1C clear of status.
- Writes to SWITCH, unmapped, or unaligned addresses are ignored. Writes use only the low bits of wdata needed by the target register.
- Reset mid-count aborts immediately; no tick pending after release.

Decomposition:
- Shared package periph_pkg holds:
  - register offsets (TH/TL/TCON/PRESC, channel stride 0x10, global offsets 0x80-0x8C);
  - TCON bit indices;
  - the global-region offset constant.
- Sub-module timer_channel (params TIMER_W, PRESC_W) holds TH/TL/TCON/PRESC, the prescaler and overflow logic.
  - Inputs: decoded per-register write strobes and wdata.
  - Outputs: register values and irq.
- The top level instantiates NUM_TIMERS channels via generate, plus the address decode, LED/DIGI registers and read mux.

Test Plan:
- Reset, then read all mapped registers -> all 0, except SWITCH = switch input; irqout=0.
- Ch0: TH=0xFFFFFFF0, TL=0xFFFFFFFD, PRESC=0, TCON=0x3 -> TL counts FE, FF, then reloads 0xFFFFFFF0. status=1; irqout rises the cycle after the reload edge.
- Ch1: PRESC=3, TL=0xFFFFFFFE, TCON=0x7 (oneshot) -> TL increments every 4 clocks. After overflow TL=TH, TCON reads 0xE (en cleared), and TL stays constant thereafter.
- W1C: with ch0 status=1, write IRQSTAT=0x1 -> status 0, irqout 0. Write TCON=0x8 in the same cycle as an overflow -> status reads 1.
- Collision: write TL=0x100 on the cycle TL would overflow -> TL=0x101 after the next tick; no reload, status unchanged.
- LED=0xA5, DIGI=0xABC, write to SWITCH address, read unmapped BASE+0x90 -> led=0xA5, digi=0xABC, SWITCH read unchanged, unmapped read=0. Assert reset mid-run -> all cleared asynchronously.

Source files
------------

// File: rtl/periph_pkg.sv
// Shared register map and TCON bit layout for the timer-bank peripheral.
// Channel registers repeat every CH_STRIDE bytes; globals sit at GLB_OFFSET.
package periph_pkg;

  localparam logic [31:0] CH_STRIDE  = 32'h10;
  localparam logic [31:0] GLB_OFFSET = 32'h80;

  // Word index within a 16-byte block: offset = index * 4.
  typedef enum logic [1:0] {
    REG_TH    = 2'd0,
    REG_TL    = 2'd1,
    REG_TCON  = 2'd2,
    REG_PRESC = 2'd3
  } ch_reg_e;

  typedef enum logic [1:0] {
    GLB_LED     = 2'd0,
    GLB_SWITCH  = 2'd1,
    GLB_DIGI    = 2'd2,
    GLB_IRQSTAT = 2'd3
  } glb_reg_e;

  localparam int TCON_EN      = 0;
  localparam int TCON_IEN     = 1;
  localparam int TCON_ONESHOT = 2;
  localparam int TCON_STATUS  = 3;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload/counter registers, prescaler, overflow and
// sticky status. Register writes arrive as pre-decoded strobes.
module timer_channel
  import periph_pkg::*;
#(
  parameter int TIMER_W = 32,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_th_we,
  input  logic               i_tl_we,
  input  logic               i_tcon_we,
  input  logic               i_presc_we,
  input  logic               i_stat_clr,
  input  logic [31:0]        i_wdata,
  output logic [TIMER_W-1:0] o_th,
  output logic [TIMER_W-1:0] o_tl,
  output logic [3:0]         o_tcon,
  output logic [PRESC_W-1:0] o_presc,
  output logic               o_irq
);

  logic [TIMER_W-1:0] r_th;
  logic [TIMER_W-1:0] r_tl;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_pcnt;
  logic               r_en;
  logic               r_ien;
  logic               r_oneshot;
  logic               r_status;

  logic w_tick;
  logic w_ovf;
  logic w_clr;
  logic w_unused;

  assign w_tick   = r_en && (r_pcnt == r_presc);
  // A CPU write to TL on the wrap cycle replaces the wrap entirely.
  assign w_ovf    = w_tick && (&r_tl) && !i_tl_we;
  assign w_clr    = i_stat_clr || (i_tcon_we && i_wdata[TCON_STATUS]);
  assign w_unused = ^i_wdata;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th      <= '0;
      r_tl      <= '0;
      r_presc   <= '0;
      r_pcnt    <= '0;
      r_en      <= 1'b0;
      r_ien     <= 1'b0;
      r_oneshot <= 1'b0;
      r_status  <= 1'b0;
    end else begin
      if (i_th_we)    r_th    <= i_wdata[TIMER_W-1:0];
      if (i_presc_we) r_presc <= i_wdata[PRESC_W-1:0];

      if (i_tl_we)     r_tl <= i_wdata[TIMER_W-1:0];
      else if (w_tick) r_tl <= (&r_tl) ? r_th : r_tl + TIMER_W'(1);

      if (!r_en || i_presc_we || i_tcon_we || w_tick) r_pcnt <= '0;
      else                                            r_pcnt <= r_pcnt + PRESC_W'(1);

      if (i_tcon_we) begin
        r_en      <= i_wdata[TCON_EN];
        r_ien     <= i_wdata[TCON_IEN];
        r_oneshot <= i_wdata[TCON_ONESHOT];
      end else if (w_ovf && r_oneshot) begin
        r_en <= 1'b0;
      end

      // Overflow set has priority over any clear in the same cycle.
      if (w_ovf)      r_status <= 1'b1;
      else if (w_clr) r_status <= 1'b0;
    end
  end

  assign o_th    = r_th;
  assign o_tl    = r_tl;
  assign o_presc = r_presc;
  assign o_irq   = r_status && r_ien;

  always_comb begin
    o_tcon               = '0;
    o_tcon[TCON_EN]      = r_en;
    o_tcon[TCON_IEN]     = r_ien;
    o_tcon[TCON_ONESHOT] = r_oneshot;
    o_tcon[TCON_STATUS]  = r_status;
  end

endmodule

// File: rtl/peripheral_timer_bank.sv
// Memory-mapped I/O block: NUM_TIMERS timer channels plus LED, switch and
// 7-segment registers, with an OR-ed interrupt line to the CPU.
module peripheral_timer_bank
  import periph_pkg::*;
#(
  parameter int          NUM_TIMERS = 2,
  parameter int          TIMER_W    = 32,
  parameter int          PRESC_W    = 16,
  parameter int          LED_W      = 8,
  parameter int          SW_W       = 8,
  parameter int          DIGI_W     = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [LED_W-1:0]      led,
  input  logic [SW_W-1:0]       switch,
  output logic [DIGI_W-1:0]     digi,
  output logic [NUM_TIMERS-1:0] irq_vec,
  output logic                  irqout
);

  logic [31:0]           w_off;
  logic                  w_aligned;
  logic                  w_glb_hit;
  ch_reg_e               w_ch_reg;
  glb_reg_e              w_glb_reg;
  logic [NUM_TIMERS-1:0] w_ch_hit;
  logic [NUM_TIMERS-1:0] w_status;

  logic [TIMER_W-1:0] w_th    [NUM_TIMERS];
  logic [TIMER_W-1:0] w_tl    [NUM_TIMERS];
  logic [3:0]         w_tcon  [NUM_TIMERS];
  logic [PRESC_W-1:0] w_presc [NUM_TIMERS];

  logic [LED_W-1:0]  r_led;
  logic [DIGI_W-1:0] r_digi;

  // Wrap-around subtraction makes any address below BASE decode as unmapped.
  assign w_off     = addr - BASE_ADDR;
  assign w_aligned = (w_off[1:0] == 2'b00);
  assign w_ch_reg  = ch_reg_e'(w_off[3:2]);
  assign w_glb_reg = glb_reg_e'(w_off[3:2]);
  assign w_glb_hit = w_aligned && ((w_off & ~32'hF) == GLB_OFFSET);

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    assign w_ch_hit[g] = w_aligned && ((w_off & ~32'hF) == CH_STRIDE * 32'(g));

    timer_channel #(
      .TIMER_W (TIMER_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_th_we    (wr && w_ch_hit[g] && (w_ch_reg == REG_TH)),
      .i_tl_we    (wr && w_ch_hit[g] && (w_ch_reg == REG_TL)),
      .i_tcon_we  (wr && w_ch_hit[g] && (w_ch_reg == REG_TCON)),
      .i_presc_we (wr && w_ch_hit[g] && (w_ch_reg == REG_PRESC)),
      .i_stat_clr (wr && w_glb_hit && (w_glb_reg == GLB_IRQSTAT) && wdata[g]),
      .i_wdata    (wdata),
      .o_th       (w_th[g]),
      .o_tl       (w_tl[g]),
      .o_tcon     (w_tcon[g]),
      .o_presc    (w_presc[g]),
      .o_irq      (irq_vec[g])
    );

    assign w_status[g] = w_tcon[g][TCON_STATUS];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led  <= '0;
      r_digi <= '0;
    end else if (wr && w_glb_hit) begin
      if (w_glb_reg == GLB_LED)  r_led  <= wdata[LED_W-1:0];
      if (w_glb_reg == GLB_DIGI) r_digi <= wdata[DIGI_W-1:0];
    end
  end

  // NOTE: rdata gets its default first so no latch is inferred.
  always_comb begin
    rdata = '0;
    if (rd) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (w_ch_hit[i]) begin
          case (w_ch_reg)
            REG_TH:    rdata = 32'(w_th[i]);
            REG_TL:    rdata = 32'(w_tl[i]);
            REG_TCON:  rdata = 32'(w_tcon[i]);
            REG_PRESC: rdata = 32'(w_presc[i]);
          endcase
        end
      end
      if (w_glb_hit) begin
        case (w_glb_reg)
          GLB_LED:     rdata = 32'(r_led);
          GLB_SWITCH:  rdata = 32'(switch);
          GLB_DIGI:    rdata = 32'(r_digi);
          GLB_IRQSTAT: rdata = 32'(w_status);
        endcase
      end
    end
  end

  assign led    = r_led;
  assign digi   = r_digi;
  assign irqout = |irq_vec;

endmodule
